// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubbles and a
// saturating count of the bubbles inserted by flushes and hazards.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_RegWrite,
    input  logic            id_MemToReg,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic [3:0]      id_ALUOp,
    input  logic [1:0]      id_ALUSrc,
    input  logic            id_RWsel,
    input  logic            id_Branch,
    input  logic            id_Jump,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_RegWrite,
    output logic            ex_MemToReg,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic [3:0]      ex_ALUOp,
    output logic [1:0]      ex_ALUSrc,
    output logic            ex_RWsel,
    output logic            ex_Branch,
    output logic            ex_Jump,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic hazard;
    logic capture;

    // Load in EX whose result the ID instruction needs; x0 is never a real dependency.
    always_comb begin
        hazard = id_valid & ex_valid & ex_MemRead & (ex_rd != '0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        capture = id_valid & ~hazard & ~flush;
    end

    // Reset already clears ex_valid, so the rst term only guarantees stall=0 while reset is held.
    assign stall = hazard & ~flush & ~rst;

    // NOTE: every register uses non-blocking assignment so all fields update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if ((flush | hazard) && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // A bubble is simply the all-zero word; capture loads the ID word verbatim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemToReg <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUOp    <= '0;
            ex_ALUSrc   <= '0;
            ex_RWsel    <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (capture) begin
            ex_valid    <= 1'b1;
            ex_RegWrite <= id_RegWrite;
            ex_MemToReg <= id_MemToReg;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_ALUOp    <= id_ALUOp;
            ex_ALUSrc   <= id_ALUSrc;
            ex_RWsel    <= id_RWsel;
            ex_Branch   <= id_Branch;
            ex_Jump     <= id_Jump;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end else begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemToReg <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUOp    <= '0;
            ex_ALUSrc   <= '0;
            ex_RWsel    <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a record-level model of the EX slot checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic        valid, rw, m2r, mr, mw;
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic        rwsel, br, j;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic [4:0]  rs1, rs2, rd;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite;
    logic [3:0] id_ALUOp;
    logic [1:0] id_ALUSrc;
    logic id_RWsel, id_Branch, id_Jump;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic id_uses_rs1, id_uses_rs2, flush;
    logic stall, ex_valid, ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite;
    logic [3:0] ex_ALUOp;
    logic [1:0] ex_ALUSrc;
    logic ex_RWsel, ex_Branch, ex_Jump;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    ex_t model;
    int  model_bubbles;
    ex_t dut_view;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc),
        .id_RWsel(id_RWsel), .id_Branch(id_Branch), .id_Jump(id_Jump),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc),
        .ex_RWsel(ex_RWsel), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    assign dut_view = {ex_valid, ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_ALUOp,
                       ex_ALUSrc, ex_RWsel, ex_Branch, ex_Jump, ex_rs1_data, ex_rs2_data,
                       ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the ID instruction depend on a load sitting in the model's EX slot?
    function automatic logic model_hazard();
        if (!(id_valid && model.valid && model.mr && model.rd != 0)) return 1'b0;
        return (id_uses_rs1 && id_rs1 == model.rd) || (id_uses_rs2 && id_rs2 == model.rd);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model = '0;
            model_bubbles = 0;
        end else begin
            if (flush || model_hazard()) begin
                if (model_bubbles < (1 << CNT_W) - 1) model_bubbles++;
                model = '0;
            end else if (id_valid) begin
                model = {1'b1, id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_ALUOp,
                         id_ALUSrc, id_RWsel, id_Branch, id_Jump, id_rs1_data, id_rs2_data,
                         id_imm, id_pc, id_rs1, id_rs2, id_rd};
            end else begin
                model = '0;
            end
        end
    end

    always @(negedge clk) begin
        check("ex_record", 256'(dut_view), 256'(model));
        check("stall", 256'(stall), 256'(model_hazard() && !flush && !rst));
        check("bubble_cnt", 256'(bubble_cnt), 256'(model_bubbles));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; the PC seeds the remaining fields so every bit moves.
    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic load,
                             input logic [31:0] pc);
        id_valid    = 1'b1;
        id_RegWrite = 1'b1;
        id_MemRead  = load;
        id_MemToReg = load;
        id_MemWrite = pc[2];
        id_ALUOp    = pc[5:2];
        id_ALUSrc   = {load, pc[3]};
        id_RWsel    = pc[3];
        id_Branch   = pc[4];
        id_Jump     = pc[6];
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = ~pc;
        id_imm      = pc + 32'd4;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        set_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        id_valid = 1'b0;
        step();
        step();
        check("reset_valid", 256'(ex_valid), 256'(0));
        check("reset_cnt", 256'(bubble_cnt), 256'(0));
        check("reset_stall", 256'(stall), 256'(0));
        rst = 1'b0;

        // add x3,x1,x2 at 0x40 flows straight through
        set_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h40);
        #1 check("add_stall", 256'(stall), 256'(0));
        step();
        check("add_rw", 256'(ex_RegWrite), 256'(1));
        check("add_rd", 256'(ex_rd), 256'(3));
        check("add_pc", 256'(ex_pc), 256'(32'h40));
        check("add_valid", 256'(ex_valid), 256'(1));

        // lw x5 then add x6,x5,x1: one stall, one bubble, then add
        set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h44);
        step();
        set_instr(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h48);
        #1 check("lu_stall", 256'(stall), 256'(1));
        step();
        check("lu_bub_valid", 256'(ex_valid), 256'(0));
        check("lu_bub_rw", 256'(ex_RegWrite), 256'(0));
        check("lu_bub_cnt", 256'(bubble_cnt), 256'(1));
        check("lu_stall_drop", 256'(stall), 256'(0));
        step();
        check("lu_add_rd", 256'(ex_rd), 256'(6));
        check("lu_add_valid", 256'(ex_valid), 256'(1));

        // load to x0 is no dependency
        set_instr(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h4C);
        step();
        set_instr(5'd0, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h50);
        #1 check("x0_stall", 256'(stall), 256'(0));
        step();
        check("x0_valid", 256'(ex_valid), 256'(1));

        // rs1 matches but is not read
        set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h54);
        step();
        set_instr(5'd5, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 32'h58);
        #1 check("nouse_stall", 256'(stall), 256'(0));
        step();
        check("nouse_cnt", 256'(bubble_cnt), 256'(1));

        // dependency through rs2
        set_instr(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h5C);
        step();
        set_instr(5'd2, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 32'h60);
        #1 check("rs2_stall", 256'(stall), 256'(1));
        step();
        check("rs2_cnt", 256'(bubble_cnt), 256'(2));
        step();
        check("rs2_rd", 256'(ex_rd), 256'(8));

        // hazard together with flush counts one bubble, no stall
        set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h64);
        step();
        set_instr(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h68);
        flush = 1'b1;
        #1 check("hzfl_stall", 256'(stall), 256'(0));
        step();
        flush = 1'b0;
        check("hzfl_valid", 256'(ex_valid), 256'(0));
        check("hzfl_cnt", 256'(bubble_cnt), 256'(3));

        // idle ID: bubble but not counted
        id_valid = 1'b0;
        step();
        check("idle_valid", 256'(ex_valid), 256'(0));
        check("idle_cnt", 256'(bubble_cnt), 256'(3));

        // reset in the middle of a stall
        set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h6C);
        step();
        set_instr(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h70);
        #1 check("rst_pre_stall", 256'(stall), 256'(1));
        rst = 1'b1;
        #1;
        check("rst_stall", 256'(stall), 256'(0));
        check("rst_valid", 256'(ex_valid), 256'(0));
        check("rst_memread", 256'(ex_MemRead), 256'(0));
        check("rst_rd", 256'(ex_rd), 256'(0));
        check("rst_pc", 256'(ex_pc), 256'(0));
        check("rst_cnt", 256'(bubble_cnt), 256'(0));
        #1 rst = 1'b0;
        step();
        check("rst_after_rd", 256'(ex_rd), 256'(6));

        // saturation: 15 flushes reach the ceiling, two more stay there
        flush = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("sat_reach", 256'(bubble_cnt), 256'(15));
        step();
        step();
        check("sat_hold", 256'(bubble_cnt), 256'(15));
        flush = 1'b0;
        id_valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
